// File: rtl/multicycle_control.sv
// multicycle_control: FSM sequencing fetch/decode/execute/memory/writeback for the multicycle MIPS-subset datapath
module multicycle_control #(
    parameter int TO_W = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opCode,
    input  logic [5:0] func,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       illegal,
    output logic       bus_err,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11,
        TRAP   = 4'd12
    } state_t;

    state_t          st, nxt;
    logic [TO_W-1:0] cnt, cnt_nxt;
    logic            wait_st, timeout, rtype_ok;

    assign wait_st  = st == FETCH || st == MEMRD || st == MEMWR;
    // the current wait cycle is the (2^TO_W-1)-th one when the counter already holds 2^TO_W-2
    assign timeout  = wait_st && !mem_ready && cnt == {{(TO_W-1){1'b1}}, 1'b0};
    assign rtype_ok = func inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    assign cnt_nxt  = (wait_st && !mem_ready && !timeout) ? cnt + TO_W'(1) : '0;
    assign state    = reset ? 4'd0 : st;

    // state register and memory-wait counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st  <= FETCH;
            cnt <= '0;
        end else begin
            st  <= nxt;
            cnt <= cnt_nxt;
        end
    end

    // next state and datapath controls; everything is forced low while reset is held
    always_comb begin
        nxt         = FETCH;
        mem_req     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = 2'b00;
        ALUOp       = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        illegal     = 1'b0;
        bus_err     = timeout;
        case (st)
            FETCH: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                nxt     = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                nxt     = opCode == 6'b000000 ? (rtype_ok ? EXEC : TRAP) :
                          (opCode == 6'b100011 || opCode == 6'b101011) ? MEMADR :
                          opCode == 6'b000100 ? BRANCH :
                          opCode == 6'b000010 ? JUMP :
                          opCode == 6'b001000 ? ADDIEX : TRAP;
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                nxt     = opCode == 6'b100011 ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                IorD    = 1'b1;
                nxt     = mem_ready ? MEMWB : timeout ? FETCH : MEMRD;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            MEMWR: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                IorD     = 1'b1;
                nxt      = (mem_ready || timeout) ? FETCH : MEMWR;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                nxt     = RWB;
            end
            RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                nxt     = ADDIWB;
            end
            ADDIWB: RegWrite = 1'b1;
            TRAP: illegal = 1'b1;
            default: ;
        endcase
        if (reset) begin
            {mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond, PCSource, ALUOp,
             ALUSrcA, ALUSrcB, RegWrite, RegDst, MemtoReg, illegal, bus_err} = '0;
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed vector table plus timeout and reset corner sequences
module tb_multicycle_control;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opCode = '0;
    logic [5:0] func = '0;
    logic       mem_ready = 1'b1;
    logic       mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond;
    logic [1:0] PCSource, ALUOp, ALUSrcB;
    logic       ALUSrcA, RegWrite, RegDst, MemtoReg, illegal, bus_err;
    logic [3:0] state;
    logic [22:0] act;
    int total = 0;
    int bad = 0;

    // layout: state, req rd wr iord irw pcw pcwc, pcsrc, aluop, srca, srcb, regw regdst m2r ill berr
    localparam logic [22:0] ZERO = '0;
    localparam logic [22:0] F_W  = {4'd0,  7'b1100000, 2'b00, 2'b00, 1'b0, 2'b01, 5'b00000};
    localparam logic [22:0] F_R  = {4'd0,  7'b1100110, 2'b00, 2'b00, 1'b0, 2'b01, 5'b00000};
    localparam logic [22:0] F_T  = {4'd0,  7'b1100000, 2'b00, 2'b00, 1'b0, 2'b01, 5'b00001};
    localparam logic [22:0] DEC  = {4'd1,  7'b0000000, 2'b00, 2'b00, 1'b0, 2'b11, 5'b00000};
    localparam logic [22:0] MADR = {4'd2,  7'b0000000, 2'b00, 2'b00, 1'b1, 2'b10, 5'b00000};
    localparam logic [22:0] MRD  = {4'd3,  7'b1101000, 2'b00, 2'b00, 1'b0, 2'b00, 5'b00000};
    localparam logic [22:0] MRDT = {4'd3,  7'b1101000, 2'b00, 2'b00, 1'b0, 2'b00, 5'b00001};
    localparam logic [22:0] MWB  = {4'd4,  7'b0000000, 2'b00, 2'b00, 1'b0, 2'b00, 5'b10100};
    localparam logic [22:0] MWR  = {4'd5,  7'b1011000, 2'b00, 2'b00, 1'b0, 2'b00, 5'b00000};
    localparam logic [22:0] EXE  = {4'd6,  7'b0000000, 2'b00, 2'b10, 1'b1, 2'b00, 5'b00000};
    localparam logic [22:0] RWB  = {4'd7,  7'b0000000, 2'b00, 2'b00, 1'b0, 2'b00, 5'b11000};
    localparam logic [22:0] BRA  = {4'd8,  7'b0000001, 2'b01, 2'b01, 1'b1, 2'b00, 5'b00000};
    localparam logic [22:0] JMP  = {4'd9,  7'b0000010, 2'b10, 2'b00, 1'b0, 2'b00, 5'b00000};
    localparam logic [22:0] AEX  = {4'd10, 7'b0000000, 2'b00, 2'b00, 1'b1, 2'b10, 5'b00000};
    localparam logic [22:0] AWB  = {4'd11, 7'b0000000, 2'b00, 2'b00, 1'b0, 2'b00, 5'b10000};
    localparam logic [22:0] TRP  = {4'd12, 7'b0000000, 2'b00, 2'b00, 1'b0, 2'b00, 5'b00010};

    typedef struct {
        string       nm;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        rdy;
        logic [22:0] exp;
    } vec_t;

    vec_t tv[$];

    always #5 clock = ~clock;

    multicycle_control #(.TO_W(4)) dut (
        .clock(clock), .reset(reset), .opCode(opCode), .func(func), .mem_ready(mem_ready),
        .mem_req(mem_req), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
        .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .illegal(illegal), .bus_err(bus_err), .state(state)
    );

    assign act = {state, mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond,
                  PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, MemtoReg, illegal, bus_err};

    task automatic chk(input string nm, input logic [22:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input string nm, input logic [5:0] op, input logic [5:0] fn,
                        input logic rdy, input logic [22:0] exp);
        @(posedge clock);
        #1;
        reset = 1'b0;
        opCode = op;
        func = fn;
        mem_ready = rdy;
        #3;
        chk(nm, exp);
    endtask

    task automatic add(input string nm, input logic [5:0] op, input logic [5:0] fn,
                       input logic rdy, input logic [22:0] exp);
        tv.push_back('{nm, op, fn, rdy, exp});
    endtask

    initial begin
        add("add_fetch", 6'h00, 6'h20, 1'b1, F_R);
        add("add_decode", 6'h00, 6'h20, 1'b1, DEC);
        add("add_exec", 6'h00, 6'h20, 1'b1, EXE);
        add("add_rwb", 6'h00, 6'h20, 1'b1, RWB);
        add("lw_fetch", 6'h23, 6'h00, 1'b1, F_R);
        add("lw_decode", 6'h23, 6'h00, 1'b1, DEC);
        add("lw_memadr", 6'h23, 6'h00, 1'b1, MADR);
        add("lw_memrd_w1", 6'h23, 6'h00, 1'b0, MRD);
        add("lw_memrd_w2", 6'h23, 6'h00, 1'b0, MRD);
        add("lw_memrd_w3", 6'h23, 6'h00, 1'b0, MRD);
        add("lw_memrd_rdy", 6'h23, 6'h00, 1'b1, MRD);
        add("lw_memwb", 6'h23, 6'h00, 1'b1, MWB);
        add("sw_fetch", 6'h2B, 6'h00, 1'b1, F_R);
        add("sw_decode", 6'h2B, 6'h00, 1'b1, DEC);
        add("sw_memadr", 6'h2B, 6'h00, 1'b1, MADR);
        add("sw_memwr_w1", 6'h2B, 6'h00, 1'b0, MWR);
        add("sw_memwr_rdy", 6'h2B, 6'h00, 1'b1, MWR);
        add("beq_fetch", 6'h04, 6'h00, 1'b1, F_R);
        add("beq_decode", 6'h04, 6'h00, 1'b1, DEC);
        add("beq_branch", 6'h04, 6'h00, 1'b1, BRA);
        add("j_fetch", 6'h02, 6'h00, 1'b1, F_R);
        add("j_decode", 6'h02, 6'h00, 1'b1, DEC);
        add("j_jump", 6'h02, 6'h00, 1'b1, JMP);
        add("addi_fetch", 6'h08, 6'h00, 1'b1, F_R);
        add("addi_decode", 6'h08, 6'h00, 1'b1, DEC);
        add("addi_exec", 6'h08, 6'h00, 1'b1, AEX);
        add("addi_wb", 6'h08, 6'h00, 1'b1, AWB);
        add("badop_fetch", 6'h3F, 6'h00, 1'b1, F_R);
        add("badop_decode", 6'h3F, 6'h00, 1'b1, DEC);
        add("badop_trap", 6'h3F, 6'h00, 1'b1, TRP);
        add("badfn_fetch", 6'h00, 6'h07, 1'b1, F_R);
        add("badfn_decode", 6'h00, 6'h07, 1'b1, DEC);
        add("badfn_trap", 6'h00, 6'h07, 1'b1, TRP);
        add("slt_fetch_w1", 6'h00, 6'h2A, 1'b0, F_W);
        add("slt_fetch_rdy", 6'h00, 6'h2A, 1'b1, F_R);
        add("slt_decode", 6'h00, 6'h2A, 1'b1, DEC);
        add("slt_exec", 6'h00, 6'h2A, 1'b1, EXE);
        add("slt_rwb", 6'h00, 6'h2A, 1'b1, RWB);
        add("sub_fetch", 6'h00, 6'h22, 1'b1, F_R);
        add("sub_decode", 6'h00, 6'h22, 1'b1, DEC);
        add("sub_exec", 6'h00, 6'h22, 1'b1, EXE);
        add("sub_rwb", 6'h00, 6'h22, 1'b1, RWB);

        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #4;
            chk("reset_outputs", ZERO);
        end
        foreach (tv[i]) step(tv[i].nm, tv[i].op, tv[i].fn, tv[i].rdy, tv[i].exp);

        for (int i = 1; i < 15; i++) step("fetch_wait", 6'h00, 6'h00, 1'b0, F_W);
        step("fetch_timeout", 6'h00, 6'h00, 1'b0, F_T);
        for (int i = 1; i < 15; i++) step("refetch_wait", 6'h23, 6'h00, 1'b0, F_W);
        step("fetch_ready_at_limit", 6'h23, 6'h00, 1'b1, F_R);
        step("lwto_decode", 6'h23, 6'h00, 1'b1, DEC);
        step("lwto_memadr", 6'h23, 6'h00, 1'b1, MADR);
        for (int i = 1; i < 15; i++) step("lwto_memrd_wait", 6'h23, 6'h00, 1'b0, MRD);
        step("lwto_memrd_timeout", 6'h23, 6'h00, 1'b0, MRDT);
        step("lwto_back_to_fetch", 6'h2B, 6'h00, 1'b1, F_R);
        step("swr_decode", 6'h2B, 6'h00, 1'b1, DEC);
        step("swr_memadr", 6'h2B, 6'h00, 1'b1, MADR);
        step("swr_memwr", 6'h2B, 6'h00, 1'b0, MWR);
        #2;
        reset = 1'b1;
        #1;
        chk("reset_mid_memwr", ZERO);
        @(posedge clock);
        #4;
        chk("reset_hold", ZERO);
        step("after_reset_fetch", 6'h00, 6'h00, 1'b0, F_W);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
